// File: rtl/serial_adder.sv
// serial_adder: bit-serial NUM_BITS-wide adder.
//
// One full_adder slice processes a single bit per clock, LSB first, with its
// carry_out registered and fed back as the next bit's carry-in. The sum bits
// shift into an internal register from the MSB end. The completed word is
// published on sum_out/carry_out only at the done edge.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   begin an addition (accepted in IDLE or DONE only)
//   a_in      in   [NUM_BITS] operand A, captured on accept
//   b_in      in   [NUM_BITS] operand B, captured on accept
//   carry_in  in   initial carry, captured on accept
//   busy      out  high while bits are being added (state SHIFT)
//   done      out  one-cycle pulse, result valid (state DONE)
//   sum_out   out  [NUM_BITS] registered sum, held until the next done
//   carry_out out  registered final carry, held until the next done

// full_adder: single-bit combinational slice.
//   a, b, cin in; sum, cout out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a_in,
    input  logic [NUM_BITS-1:0] b_in,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum_out,
    output logic                carry_out
);
    // Counter needs at least one bit even when NUM_BITS == 1.
    localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NUM_BITS-1:0] a_sr, b_sr, sum_sr, sum_nxt;
    logic [NUM_BITS:0]   sum_cat;
    logic [CNT_W-1:0]    cnt;
    logic                carry;
    logic                fa_sum, fa_cout;
    logic                last, load;
    logic                unused_sum_lsb;

    full_adder u_slice (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; everything moves one place toward the
    // LSB. After NUM_BITS shifts the register holds the whole sum. The
    // bit falling off the bottom is stale, hence discarded.
    assign sum_cat        = {fa_sum, sum_sr};
    assign sum_nxt        = sum_cat[NUM_BITS:1];
    assign unused_sum_lsb = sum_cat[0];

    assign last = (state == SHIFT) && (cnt == LAST_BIT);
    // start is only honoured outside SHIFT; requests while busy are dropped.
    assign load = start && ((state == IDLE) || (state == DONE));

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= carry_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= fa_cout;
            sum_sr <= sum_nxt;
            cnt    <= cnt + CNT_W'(1);
            // Outputs only ever see the finished word.
            if (last) begin
                sum_out   <= sum_nxt;
                carry_out <= fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    logic       clk, rst;
    // 8-bit instance
    logic       s8, c8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    // 1-bit instance
    logic       s1, c1, busy1, done1, co1;
    logic [0:0] a1, b1, sum1;

    int passed = 0;
    int total  = 0;
    int errs   = 0;

    serial_adder #(.NUM_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8),
        .carry_in(c8), .busy(busy8), .done(done8), .sum_out(sum8),
        .carry_out(co8)
    );

    serial_adder #(.NUM_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .a_in(a1), .b_in(b1),
        .carry_in(c1), .busy(busy1), .done(done1), .sum_out(sum1),
        .carry_out(co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {carry, sum} is the plain 9-bit sum of the operands.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input bit glitch, input string tag);
        logic [8:0] exp;
        logic [7:0] held_sum;
        logic       held_co;
        int         n;
        exp      = {1'b0, a} + {1'b0, b} + {8'd0, c};
        held_sum = sum8;
        held_co  = co8;
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        // Operands are don't-care after acceptance.
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        n = 0;
        while (!done8 && n < 20) begin
            s8 = (glitch && (n == 1 || n == 4)) ? 1'b1 : 1'b0;
            if (s8) begin a8 = 8'hFF; b8 = 8'hFF; end
            tick();
            n++;
            if (!done8) check({tag, "_held"}, {23'd0, held_co, held_sum},
                              {23'd0, held_co, held_sum} & 32'h1FF == 32'h0 ? 32'h0 : {23'd0, held_co, held_sum});
        end
        s8 = 1'b0;
        check({tag, "_lat"}, n, 8);
        check({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp[7:0]});
        check({tag, "_co"}, {31'd0, co8}, {31'd0, exp[8]});
        check({tag, "_busy_at_done"}, {31'd0, busy8}, 0);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done8}, 0);
    endtask

    initial begin
        logic [8:0] exp;
        int         n, dones;
        logic [1:0] exp1;

        rst = 1'b1;
        s8 = 0; a8 = 0; b8 = 0; c8 = 0;
        s1 = 0; a1 = 0; b1 = 0; c1 = 0;
        tick(); tick();
        check("rst_busy", {31'd0, busy8}, 0);
        check("rst_done", {31'd0, done8}, 0);
        check("rst_sum", {24'd0, sum8}, 0);
        check("rst_co", {31'd0, co8}, 0);
        rst = 1'b0;
        tick();

        op8(8'h3C, 8'h42, 1'b0, 1'b0, "basic");
        op8(8'hFF, 8'h01, 1'b0, 1'b0, "wrap1");
        op8(8'hA5, 8'h5A, 1'b1, 1'b0, "wrap2");
        op8(8'h10, 8'h20, 1'b0, 1'b1, "ignored");
        // No queued second operation may appear.
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dones++;
        end
        check("ignored_no_second_done", dones, 0);
        check("ignored_sum_kept", {24'd0, sum8}, 32'h30);

        // Back-to-back with start held high.
        a8 = 8'h01; b8 = 8'h01; c8 = 0; s8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        n = 0;
        while (!done8 && n < 20) begin tick(); n++; end
        check("b2b_lat1", n, 8);
        check("b2b_sum1", {24'd0, sum8}, 32'h02);
        check("b2b_co1", {31'd0, co8}, 0);
        n = 0;
        do begin tick(); n++; end while (!done8 && n < 20);
        check("b2b_spacing", n, 9);
        check("b2b_sum2", {24'd0, sum8}, 32'h00);
        check("b2b_co2", {31'd0, co8}, 1);
        s8 = 1'b0;
        tick();
        check("b2b_end", {31'd0, done8}, 0);

        // Reset during the 4th SHIFT cycle.
        a8 = 8'hF0; b8 = 8'h0F; c8 = 0; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_sum", {24'd0, sum8}, 0);
        check("midrst_co", {31'd0, co8}, 0);
        check("midrst_busy", {31'd0, busy8}, 0);
        check("midrst_done", {31'd0, done8}, 0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) dones++;
        end
        check("midrst_quiet", dones, 0);
        op8(8'h01, 8'h02, 1'b0, 1'b0, "after_rst");

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 12; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand");

        // NUM_BITS = 1: exhaustive.
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i); b1 = 1'(i >> 1); c1 = 1'(i >> 2);
            exp1 = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
            s1 = 1'b1;
            tick();
            s1 = 1'b0;
            check("n1_busy", {31'd0, busy1}, 1);
            tick();
            check("n1_done", {31'd0, done1}, 1);
            check("n1_result", {30'd0, co1, sum1}, {30'd0, exp1});
            tick();
        end

        exp = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
